// File: rtl/xor_bist_pkg.sv
// Shared types and helpers for the XOR-gate BIST sequencer.
// Optional capture of the first failing vector is enabled by XOR_BIST_FAIL_CAPTURE_EN.
package xor_bist_pkg;

   localparam int unsigned MAX_N_INPUTS = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StApply = 2'd1,
      StCheck = 2'd2,
      StDone  = 2'd3
   } bist_state_e;

   // Reference parity; narrower vectors are zero-extended by the caller.
   function automatic logic parity_ref(input logic [MAX_N_INPUTS-1:0] vec);
      return ^vec;
   endfunction

endpackage

// File: rtl/xor_bist_patgen.sv
// Exhaustive pattern register for the gate under test: clear, increment, last-vector flag.
// Used by xor_bist_ctrl (optional XOR_BIST_FAIL_CAPTURE_EN does not affect this block).
module xor_bist_patgen
   import xor_bist_pkg::*;
#(
   parameter int unsigned N_INPUTS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                inc,
   output logic [N_INPUTS-1:0] vec,
   output logic                last
);

   logic [N_INPUTS-1:0] vec_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q <= '0;
      end else if (clr) begin
         vec_q <= '0;
      end else if (inc) begin
         vec_q <= vec_q + 1'b1;
      end
   end

   assign vec  = vec_q;
   assign last = &vec_q;

endmodule

// File: rtl/xor_bist_ctrl.sv
// BIST sequencer: walks all 2^N input patterns through one XOR gate and counts parity mismatches.
// Define XOR_BIST_FAIL_CAPTURE_EN to add first_fail_vec/first_fail_vld capture of the first mismatch.
module xor_bist_ctrl
   import xor_bist_pkg::*;
#(
   parameter int unsigned N_INPUTS      = 5,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic [N_INPUTS-1:0] dut_i,
   input  logic                dut_o,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ERR_W-1:0]    err_cnt,
   output logic [N_INPUTS-1:0] vec_idx
`ifdef XOR_BIST_FAIL_CAPTURE_EN
   ,
   output logic [N_INPUTS-1:0] first_fail_vec,
   output logic                first_fail_vld
`endif
);

   localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ErrMax = '1;

   bist_state_e         state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [N_INPUTS-1:0] vec;
   logic                vec_last;
   logic                vec_clr;
   logic                vec_inc;
   logic                start_acc;
   logic                mismatch;

   xor_bist_patgen #(
      .N_INPUTS(N_INPUTS)
   ) u_patgen (
      .clk (clk),
      .rst (rst),
      .clr (vec_clr),
      .inc (vec_inc),
      .vec (vec),
      .last(vec_last)
   );

   // start is only honoured when no run is in flight.
   assign start_acc = start && ((state_q == StIdle) || (state_q == StDone));
   assign mismatch  = (state_q == StCheck) && (dut_o != parity_ref(MAX_N_INPUTS'(vec)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      vec_clr = 1'b0;
      vec_inc = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_acc) begin
               state_d = StApply;
               cnt_d   = '0;
               err_d   = '0;
               vec_clr = 1'b1;
            end
         end
         StApply: begin
            if (cnt_q == CntLast) begin
               state_d = StCheck;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StCheck: begin
            if (mismatch && (err_q != ErrMax)) begin
               err_d = err_q + 1'b1;
            end
            cnt_d = '0;
            if (vec_last) begin
               state_d = StDone;
            end else begin
               state_d = StApply;
               vec_inc = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign dut_i   = vec;
   assign vec_idx = vec;
   assign busy    = (state_q == StApply) || (state_q == StCheck);
   assign done    = (state_q == StDone);
   assign pass    = done && (err_q == '0);
   assign err_cnt = err_q;

`ifdef XOR_BIST_FAIL_CAPTURE_EN
   logic [N_INPUTS-1:0] ff_vec_q;
   logic                ff_vld_q;

   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         ff_vec_q <= '0;
         ff_vld_q <= 1'b0;
      end else if (mismatch && !ff_vld_q) begin
         ff_vec_q <= vec;
         ff_vld_q <= 1'b1;
      end
   end

   assign first_fail_vec = ff_vec_q;
   assign first_fail_vld = ff_vld_q;
`endif

endmodule

// File: tb/tb_xor_bist_ctrl.sv
// Self-checking bench for xor_bist_ctrl; vector order is checked against a per-instance queue.
// Capture checks are compiled in only when XOR_BIST_FAIL_CAPTURE_EN is defined.
module tb_xor_bist_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned tests_run    = 0;
   int unsigned tests_failed = 0;

   // Gate models: 0 golden, 1 inverted, 2 stuck-at-0, 3 wrong only on vector 6.
   function automatic logic gate_model(input logic [1:0] mode, input logic [7:0] vec);
      case (mode)
         2'd0:    return ^vec;
         2'd1:    return ~(^vec);
         2'd2:    return 1'b0;
         default: return (vec == 8'd6) ? ~(^vec) : ^vec;
      endcase
   endfunction

   // u_a: N=5 S=2 ERR_W=8; u_b: N=3 S=1 ERR_W=8; u_c: N=5 S=2 ERR_W=4
   logic       rst_a, start_a, dut_o_a, busy_a, done_a, pass_a;
   logic [4:0] dut_i_a, vec_idx_a;
   logic [7:0] err_a;
   logic [1:0] mode_a;
   logic       rst_b, start_b, dut_o_b, busy_b, done_b, pass_b;
   logic [2:0] dut_i_b, vec_idx_b;
   logic [7:0] err_b;
   logic [1:0] mode_b;
   logic       rst_c, start_c, dut_o_c, busy_c, done_c, pass_c;
   logic [4:0] dut_i_c, vec_idx_c;
   logic [3:0] err_c;
   logic [1:0] mode_c;
`ifdef XOR_BIST_FAIL_CAPTURE_EN
   logic [4:0] ffv_a, ffv_c;
   logic [2:0] ffv_b;
   logic       ffl_a, ffl_b, ffl_c;
`endif

   assign dut_o_a = gate_model(mode_a, 8'(dut_i_a));
   assign dut_o_b = gate_model(mode_b, 8'(dut_i_b));
   assign dut_o_c = gate_model(mode_c, 8'(dut_i_c));

   xor_bist_ctrl #(.N_INPUTS(5), .SETTLE_CYCLES(2), .ERR_W(8)) u_a (
      .clk(clk), .rst(rst_a), .start(start_a), .dut_i(dut_i_a), .dut_o(dut_o_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .vec_idx(vec_idx_a)
`ifdef XOR_BIST_FAIL_CAPTURE_EN
      , .first_fail_vec(ffv_a), .first_fail_vld(ffl_a)
`endif
   );

   xor_bist_ctrl #(.N_INPUTS(3), .SETTLE_CYCLES(1), .ERR_W(8)) u_b (
      .clk(clk), .rst(rst_b), .start(start_b), .dut_i(dut_i_b), .dut_o(dut_o_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .vec_idx(vec_idx_b)
`ifdef XOR_BIST_FAIL_CAPTURE_EN
      , .first_fail_vec(ffv_b), .first_fail_vld(ffl_b)
`endif
   );

   xor_bist_ctrl #(.N_INPUTS(5), .SETTLE_CYCLES(2), .ERR_W(4)) u_c (
      .clk(clk), .rst(rst_c), .start(start_c), .dut_i(dut_i_c), .dut_o(dut_o_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c), .vec_idx(vec_idx_c)
`ifdef XOR_BIST_FAIL_CAPTURE_EN
      , .first_fail_vec(ffv_c), .first_fail_vld(ffl_c)
`endif
   );

   // Scoreboards: expected vector sequence, popped whenever a new vector appears while busy.
   logic [4:0] q_a[$];
   logic [2:0] q_b[$];
   logic [4:0] q_c[$];
   logic       mon_busy_a = 1'b0, mon_busy_b = 1'b0, mon_busy_c = 1'b0;
   logic [4:0] mon_vec_a = '0, mon_vec_c = '0;
   logic [2:0] mon_vec_b = '0;

   always @(posedge clk) begin
      #1;
      if (busy_a && (!mon_busy_a || vec_idx_a != mon_vec_a)) begin
         tests_run++;
         if (q_a.size() == 0) begin
            tests_failed++;
            $display("FAIL a_vec_seq: got vec %0d, expected none", vec_idx_a);
         end else begin
            if (vec_idx_a !== q_a[0]) begin
               tests_failed++;
               $display("FAIL a_vec_seq: got vec %0d, expected %0d", vec_idx_a, q_a[0]);
            end
            void'(q_a.pop_front());
         end
         tests_run++;
         if (dut_i_a !== vec_idx_a) begin
            tests_failed++;
            $display("FAIL a_dut_i: got %0d, expected %0d", dut_i_a, vec_idx_a);
         end
      end
      mon_busy_a <= busy_a;
      mon_vec_a  <= vec_idx_a;
   end

   always @(posedge clk) begin
      #1;
      if (busy_b && (!mon_busy_b || vec_idx_b != mon_vec_b)) begin
         tests_run++;
         if (q_b.size() == 0) begin
            tests_failed++;
            $display("FAIL b_vec_seq: got vec %0d, expected none", vec_idx_b);
         end else begin
            if (vec_idx_b !== q_b[0] || dut_i_b !== q_b[0]) begin
               tests_failed++;
               $display("FAIL b_vec_seq: got vec %0d dut_i %0d, expected %0d",
                        vec_idx_b, dut_i_b, q_b[0]);
            end
            void'(q_b.pop_front());
         end
      end
      mon_busy_b <= busy_b;
      mon_vec_b  <= vec_idx_b;
   end

   always @(posedge clk) begin
      #1;
      if (busy_c && (!mon_busy_c || vec_idx_c != mon_vec_c)) begin
         tests_run++;
         if (q_c.size() == 0) begin
            tests_failed++;
            $display("FAIL c_vec_seq: got vec %0d, expected none", vec_idx_c);
         end else begin
            if (vec_idx_c !== q_c[0] || dut_i_c !== q_c[0]) begin
               tests_failed++;
               $display("FAIL c_vec_seq: got vec %0d dut_i %0d, expected %0d",
                        vec_idx_c, dut_i_c, q_c[0]);
            end
            void'(q_c.pop_front());
         end
      end
      mon_busy_c <= busy_c;
      mon_vec_c  <= vec_idx_c;
   end

   // Cycle numbering: the cycle right after the start-sampling edge is cycle 1.
   task automatic wait_done_a(output int cyc);
      cyc = 1;
      while (done_a !== 1'b1 && cyc < 300) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic wait_done_b(output int cyc);
      cyc = 1;
      while (done_b !== 1'b1 && cyc < 300) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic wait_done_c(output int cyc);
      cyc = 1;
      while (done_c !== 1'b1 && cyc < 300) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({busy_a, done_a, pass_a, err_a, vec_idx_a, dut_i_a} !== '0) begin
         tests_failed++;
         $display("FAIL reset_a: got busy %b done %b pass %b err %0d vec %0d, expected all 0",
                  busy_a, done_a, pass_a, err_a, vec_idx_a);
      end
      tests_run++;
      if ({busy_b, done_b, pass_b, err_b, vec_idx_b, dut_i_b} !== '0) begin
         tests_failed++;
         $display("FAIL reset_b: got busy %b done %b pass %b err %0d vec %0d, expected all 0",
                  busy_b, done_b, pass_b, err_b, vec_idx_b);
      end
      tests_run++;
      if ({busy_c, done_c, pass_c, err_c, vec_idx_c, dut_i_c} !== '0) begin
         tests_failed++;
         $display("FAIL reset_c: got busy %b done %b pass %b err %0d vec %0d, expected all 0",
                  busy_c, done_c, pass_c, err_c, vec_idx_c);
      end
`ifdef XOR_BIST_FAIL_CAPTURE_EN
      tests_run++;
      if ({ffl_a, ffv_a, ffl_b, ffv_b} !== '0) begin
         tests_failed++;
         $display("FAIL reset_capture: got vld %b/%b, expected 0/0", ffl_a, ffl_b);
      end
`endif
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_no_start: got busy %b done %b, expected 0 0", busy_a, done_a);
      end
   endtask

   task automatic test_golden();
      int cyc;
      mode_a = 2'd0;
      for (int i = 0; i < 32; i++) q_a.push_back(5'(i));
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      wait_done_a(cyc);
      tests_run++;
      if (cyc != 97) begin
         tests_failed++;
         $display("FAIL golden_done_cycle: got %0d, expected 97", cyc);
      end
      tests_run++;
      if (pass_a !== 1'b1 || err_a !== 8'd0 || busy_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL golden_result: got pass %b err %0d busy %b, expected 1 0 0",
                  pass_a, err_a, busy_a);
      end
      tests_run++;
      if (q_a.size() != 0 || vec_idx_a !== 5'd31) begin
         tests_failed++;
         $display("FAIL golden_all_vectors: got %0d left, last vec %0d, expected 0 left, 31",
                  q_a.size(), vec_idx_a);
      end
   endtask

   task automatic test_stuck0();
      int cyc;
      mode_b = 2'd2;
      for (int i = 0; i < 8; i++) q_b.push_back(3'(i));
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      wait_done_b(cyc);
      tests_run++;
      if (cyc != 17) begin
         tests_failed++;
         $display("FAIL stuck0_done_cycle: got %0d, expected 17", cyc);
      end
      tests_run++;
      if (err_b !== 8'd4 || pass_b !== 1'b0) begin
         tests_failed++;
         $display("FAIL stuck0_result: got err %0d pass %b, expected 4 0", err_b, pass_b);
      end
      tests_run++;
      if (q_b.size() != 0) begin
         tests_failed++;
         $display("FAIL stuck0_all_vectors: got %0d left, expected 0", q_b.size());
      end
   endtask

   task automatic test_saturate();
      int cyc;
      mode_c = 2'd1;
      for (int i = 0; i < 32; i++) q_c.push_back(5'(i));
      start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      wait_done_c(cyc);
      tests_run++;
      if (cyc != 97) begin
         tests_failed++;
         $display("FAIL sat_done_cycle: got %0d, expected 97", cyc);
      end
      tests_run++;
      if (err_c !== 4'd15 || pass_c !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_result: got err %0d pass %b, expected 15 0", err_c, pass_c);
      end
   endtask

   task automatic test_rst_midrun();
      int cyc;
      mode_b = 2'd2;
      for (int i = 0; i < 8; i++) q_b.push_back(3'(i));
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      // cycle 10: vectors 1 and 2 have already been counted as mismatches
      tests_run++;
      if (busy_b !== 1'b1 || err_b !== 8'd2) begin
         tests_failed++;
         $display("FAIL midrun_state: got busy %b err %0d, expected 1 2", busy_b, err_b);
      end
      rst_b = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b0;
      q_b.delete();
      tests_run++;
      if ({busy_b, done_b, pass_b, err_b, vec_idx_b, dut_i_b} !== '0) begin
         tests_failed++;
         $display("FAIL midrun_abort: got busy %b done %b err %0d vec %0d, expected all 0",
                  busy_b, done_b, err_b, vec_idx_b);
      end
      rst_b = 1'b1; start_b = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b0; start_b = 1'b0;
      tests_run++;
      if (busy_b !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_beats_start: got busy %b, expected 0", busy_b);
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      tests_run++;
      if (busy_b !== 1'b0 || done_b !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_rst_idle: got busy %b done %b, expected 0 0", busy_b, done_b);
      end
      mode_b = 2'd0;
      for (int i = 0; i < 8; i++) q_b.push_back(3'(i));
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      wait_done_b(cyc);
      tests_run++;
      if (cyc != 17 || pass_b !== 1'b1 || err_b !== 8'd0) begin
         tests_failed++;
         $display("FAIL post_rst_run: got cycle %0d pass %b err %0d, expected 17 1 0",
                  cyc, pass_b, err_b);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      mode_a = 2'd1;
      for (int i = 0; i < 32; i++) q_a.push_back(5'(i));
      start_a = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      // start stays high well into the run and must be ignored while busy
      while (done_a !== 1'b1 && cyc < 300) begin
         @(posedge clk); #1; cyc++;
         if (cyc == 60) start_a = 1'b0;
      end
      tests_run++;
      if (cyc != 97) begin
         tests_failed++;
         $display("FAIL held_start_done_cycle: got %0d, expected 97", cyc);
      end
      tests_run++;
      if (err_a !== 8'd32 || pass_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL held_start_result: got err %0d pass %b, expected 32 0", err_a, pass_a);
      end
      mode_a = 2'd0;
      for (int i = 0; i < 32; i++) q_a.push_back(5'(i));
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      tests_run++;
      if (done_a !== 1'b0 || err_a !== 8'd0 || busy_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL restart_clear: got done %b err %0d busy %b, expected 0 0 1",
                  done_a, err_a, busy_a);
      end
      wait_done_a(cyc);
      tests_run++;
      if (cyc != 97 || pass_a !== 1'b1 || q_a.size() != 0) begin
         tests_failed++;
         $display("FAIL restart_run: got cycle %0d pass %b left %0d, expected 97 1 0",
                  cyc, pass_a, q_a.size());
      end
   endtask

   task automatic test_fail_capture();
      int cyc;
      mode_b = 2'd3;
      for (int i = 0; i < 8; i++) q_b.push_back(3'(i));
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      wait_done_b(cyc);
      tests_run++;
      if (cyc != 17 || err_b !== 8'd1 || pass_b !== 1'b0) begin
         tests_failed++;
         $display("FAIL vec6_result: got cycle %0d err %0d pass %b, expected 17 1 0",
                  cyc, err_b, pass_b);
      end
`ifdef XOR_BIST_FAIL_CAPTURE_EN
      tests_run++;
      if (ffv_b !== 3'b110 || ffl_b !== 1'b1) begin
         tests_failed++;
         $display("FAIL capture: got vec %b vld %b, expected 110 1", ffv_b, ffl_b);
      end
      mode_b = 2'd0;
      for (int i = 0; i < 8; i++) q_b.push_back(3'(i));
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      tests_run++;
      if (ffl_b !== 1'b0 || ffv_b !== 3'b000) begin
         tests_failed++;
         $display("FAIL capture_clear: got vec %b vld %b, expected 000 0", ffv_b, ffl_b);
      end
      wait_done_b(cyc);
      tests_run++;
      if (ffl_b !== 1'b0 || pass_b !== 1'b1) begin
         tests_failed++;
         $display("FAIL capture_clean_run: got vld %b pass %b, expected 0 1", ffl_b, pass_b);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_golden();
      test_stuck0();
      test_saturate();
      test_rst_midrun();
      test_back_to_back();
      test_fail_capture();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/xor_bist_ctrl.md
Name: xor_bist_ctrl

Overview:
- Built-in self-test sequencer for the N-input XOR gates (XOR2_E/XOR3_E/XOR5_E family).
- On start, drives every input pattern 0..2^N-1 into the gate, waits a settle window, and compares the gate output against reference parity.
- Counts mismatches and reports pass/fail.
- Sits between a test-mode register interface and one XOR gate instance.

Parameters:
- N_INPUTS, 5, width of the gate under test; legal range 2..8.
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; must be >= 1.
- ERR_W, 8, error counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a test run; sampled only in IDLE or DONE.
- dut_i  output  N_INPUTS  vector driven to the gate inputs; bit 0 goes to i1, bit N-1 to iN.
- dut_o  input  1  gate output o.
- busy  output  1  high in APPLY and CHECK.
- done  output  1  high in DONE; held until the next start or rst.
- pass  output  1  valid while done is high; 1 iff err_cnt == 0.
- err_cnt  output  ERR_W  mismatch count, saturating.
- vec_idx  output  N_INPUTS  vector currently applied; equals dut_i.

Behaviour:
- Reset: all outputs 0, state IDLE.
  - rst has priority over every other event.
  - rst mid-run aborts the run immediately; no partial result is kept.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE: when start=1, set vec=0, err_cnt=0, settle counter=0, go to APPLY.
- APPLY: dut_i=vec. Counter increments each cycle. When counter == SETTLE_CYCLES-1, go to CHECK.
- CHECK (1 cycle):
  - Sample dut_o and compare with ^vec.
  - On mismatch, err_cnt+1, saturating at 2^ERR_W-1 (no wrap).
  - If vec == all ones, go to DONE. Otherwise vec+1, reset counter, go to APPLY.
  - vec must not wrap; the all-ones test ends the run.
- DONE: done=1; pass=(err_cnt==0). dut_i holds the last vector.
  - start=1 in DONE restarts exactly as from IDLE: done drops and err_cnt clears the next cycle.
- start while busy is ignored; no queuing.
- start and rst in the same cycle: rst wins.
- Timing: start sampled at cycle t gives APPLY of vector 0 at t+1.
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises at t+1+2^N*(SETTLE_CYCLES+1).
- Comparison uses the dut_o value registered in the CHECK cycle only.

Optional Feature:
- Macro: XOR_BIST_FAIL_CAPTURE_EN.
- Defined:
  - Adds output first_fail_vec (N_INPUTS) and output first_fail_vld (1).
  - On the first mismatch of a run, capture vec and set vld. Both clear on start and on rst.
- Undefined: these ports do not exist and no capture logic is built.

Decomposition:
- Package xor_bist_pkg holds:
  - the state typedef (2-bit enum IDLE=0, APPLY=1, CHECK=2, DONE=3);
  - the constant MAX_N_INPUTS=8;
  - the function parity_ref(vec) returning ^vec.
- Sub-module xor_bist_patgen (natural split): vector register with clear/increment and last flag (vec == all ones). The FSM, settle counter and error counter stay in xor_bist_ctrl.

Test Plan:
- Golden XOR5_E, N=5, S=2, start at cycle 0: 32 vectors applied in order 0..31; done rises at cycle 97; pass=1; err_cnt=0.
- Stuck-at-0 output model, N=3, S=1: the 4 odd-parity vectors mismatch; err_cnt=4; pass=0; done at cycle 17.
- Inverted output model, N=5, ERR_W=4: 32 mismatches; err_cnt saturates at 15, no wrap; pass=0.
- rst pulsed at cycle 20 mid-run, N=3: the next cycle all outputs are 0 and state is IDLE; start at cycle 25 gives a full clean run with done at cycle 25+1+8*(S+1).
- start held high during the run and start asserted in DONE: the busy-time start is ignored and vec sequence is unchanged; start in DONE clears err_cnt and done and reruns from vector 0.
- With XOR_BIST_FAIL_CAPTURE_EN, model failing only on vector 6, N=3: first_fail_vec=3'b110, first_fail_vld=1, err_cnt=1. Without the macro, the same run compiles with no extra ports.
